// File: rtl/ram_word_sequencer.sv
// ram_word_sequencer
// Sequences 8/16/32-bit MIPS load/store requests onto a byte-wide data RAM.
// One RAM byte access per cycle. Data is assembled and split big-endian:
// the lowest address carries the most-significant byte.
//
// Parameters
//   ADDR_W      RAM byte-address width. Addresses wrap modulo 2^ADDR_W. Must be >= 2.
//   RD_LATENCY  0: DataOut is valid in the same cycle as Address.
//               1: DataOut is valid in the following cycle.
//
// Ports
//   Clk, Reset            rising-edge clock and synchronous active-high reset
//   Req/Wr/Size/Signed    request strobe (sampled only in IDLE), store/load,
//                         size (00 byte, 01 half, 1x word), sign-extend loads
//   Addr, WData           byte address and right-justified store data
//   RData                 load result, held until the next Done
//   Busy, Done, AlignErr  status: busy outside IDLE, one-cycle completion pulse,
//                         misalignment flag (pulses with Done)
//   Enable, ReadWrite,    RAM interface. This block is the RAM's only driver.
//   Address, DataIn,
//   DataOut
//
// Optional feature: define RAM_SEQ_ALIGN_CHECK_EN to reject misaligned half/word
// requests with AlignErr. Without it, misaligned low address bits are cleared and
// the access proceeds normally.
module ram_word_sequencer #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RD_LATENCY = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              Wr,
  input  logic [1:0]        Size,
  input  logic              Signed,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WData,
  output logic [31:0]       RData,
  output logic              Busy,
  output logic              Done,
  output logic              AlignErr,
  output logic              Enable,
  output logic              ReadWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [7:0]        DataIn,
  input  logic [7:0]        DataOut
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StXfer = 2'd1;
  localparam logic [1:0] StTail = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam bit LatRead1 = (RD_LATENCY == 1);

  logic [1:0]        state_q, state_d;
  logic              wr_q, wr_d;
  logic              sgn_q, sgn_d;
  logic [1:0]        last_q, last_d;   // byte count minus one
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wsh_q, wsh_d;     // store bytes, next byte to send in [31:24]
  logic [31:0]       rsh_q, rsh_d;     // load bytes shifted in from the right
  logic [31:0]       rdata_q, rdata_d;
  logic              aerr_q, aerr_d;

  logic [1:0]        req_last;
  logic [ADDR_W-1:0] req_base;
  logic              req_misal;
  logic              capture;
  logic [31:0]       rd_asm;

  always_comb begin
    unique case (Size)
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
    req_base = {Addr[ADDR_W-1:2], Addr[1:0] & ~req_last};
  end

`ifdef RAM_SEQ_ALIGN_CHECK_EN
  assign req_misal = (Addr[1:0] & req_last) != 2'b00;
`else
  // No rejection: misaligned bits are simply dropped from the base address.
  assign req_misal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    sgn_d   = sgn_q;
    last_d  = last_q;
    idx_d   = idx_q;
    base_d  = base_q;
    wsh_d   = wsh_q;
    rdata_d = rdata_q;
    aerr_d  = aerr_q;

    // With a registered RAM the byte for slot idx arrives one cycle late, so the
    // first XFER cycle captures nothing and TAIL captures the last byte.
    capture = !wr_q && ((state_q == StXfer && (!LatRead1 || idx_q != 2'd0)) ||
                        state_q == StTail);
    rsh_d   = capture ? {rsh_q[23:0], DataOut} : rsh_q;

    unique case (last_q)
      2'd0:    rd_asm = {{24{sgn_q & rsh_d[7]}}, rsh_d[7:0]};
      2'd1:    rd_asm = {{16{sgn_q & rsh_d[15]}}, rsh_d[15:0]};
      default: rd_asm = rsh_d;
    endcase

    unique case (state_q)
      StIdle: begin
        if (Req) begin
          wr_d   = Wr;
          sgn_d  = Signed;
          last_d = req_last;
          base_d = req_base;
          idx_d  = 2'd0;
          aerr_d = req_misal;
          // Left-justify so every XFER cycle sends wsh_q[31:24].
          unique case (req_last)
            2'd0:    wsh_d = {WData[7:0], 24'h0};
            2'd1:    wsh_d = {WData[15:0], 16'h0};
            default: wsh_d = WData;
          endcase
          state_d = req_misal ? StDone : StXfer;
        end
      end
      StXfer: begin
        idx_d = idx_q + 2'd1;
        wsh_d = {wsh_q[23:0], 8'h0};
        if (idx_q == last_q) begin
          state_d = (!wr_q && LatRead1) ? StTail : StDone;
          if (!wr_q && !LatRead1) rdata_d = rd_asm;
        end
      end
      StTail: begin
        state_d = StDone;
        rdata_d = rd_asm;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      last_q  <= 2'd0;
      idx_q   <= 2'd0;
      base_q  <= '0;
      wsh_q   <= '0;
      rsh_q   <= '0;
      rdata_q <= '0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      sgn_q   <= sgn_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      wsh_q   <= wsh_d;
      rsh_q   <= rsh_d;
      rdata_q <= rdata_d;
      aerr_q  <= aerr_d;
    end
  end

  // RAM-side outputs decode from registered state only.
  always_comb begin
    Enable    = (state_q == StXfer);
    ReadWrite = Enable & wr_q;
    Address   = Enable ? base_q + {{(ADDR_W-2){1'b0}}, idx_q} : '0;
    DataIn    = Enable ? wsh_q[31:24] : 8'h0;
    Busy      = (state_q != StIdle);
    Done      = (state_q == StDone);
    AlignErr  = Done & aerr_q;
    RData     = rdata_q;
  end

endmodule

// File: tb/tb_ram_word_sequencer.sv
module tb_ram_word_sequencer;
  localparam int AW = 10;
  localparam int MSZ = 1 << AW;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Req = 1'b0;
  logic          Wr = 1'b0;
  logic [1:0]    Size = 2'b00;
  logic          Signed = 1'b0;
  logic [AW-1:0] Addr = '0;
  logic [31:0]   WData = '0;

  logic [31:0]   RData0, RData1;
  logic          Busy0, Busy1, Done0, Done1, AlignErr0, AlignErr1;
  logic          Enable0, Enable1, ReadWrite0, ReadWrite1;
  logic [AW-1:0] Address0, Address1;
  logic [7:0]    DataIn0, DataIn1, dout0, dout1;

  ram_word_sequencer #(.ADDR_W(AW), .RD_LATENCY(0)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .Size(Size), .Signed(Signed),
    .Addr(Addr), .WData(WData), .RData(RData0), .Busy(Busy0), .Done(Done0),
    .AlignErr(AlignErr0), .Enable(Enable0), .ReadWrite(ReadWrite0),
    .Address(Address0), .DataIn(DataIn0), .DataOut(dout0)
  );

  ram_word_sequencer #(.ADDR_W(AW), .RD_LATENCY(1)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .Size(Size), .Signed(Signed),
    .Addr(Addr), .WData(WData), .RData(RData1), .Busy(Busy1), .Done(Done1),
    .AlignErr(AlignErr1), .Enable(Enable1), .ReadWrite(ReadWrite1),
    .Address(Address1), .DataIn(DataIn1), .DataOut(dout1)
  );

  always #5 Clk = ~Clk;

  // RAM models: combinational read for dut0, registered read for dut1.
  logic [7:0] mem0 [MSZ];
  logic [7:0] mem1 [MSZ];
  logic [7:0] gold [MSZ];
  logic       ram_clr = 1'b1;

  always @(posedge Clk) begin
    if (ram_clr) begin
      for (int i = 0; i < MSZ; i++) begin
        mem0[i] <= 8'h0;
        mem1[i] <= 8'h0;
      end
    end else begin
      if (Enable0 && ReadWrite0) mem0[Address0] <= DataIn0;
      if (Enable1 && ReadWrite1) mem1[Address1] <= DataIn1;
    end
    dout1 <= mem1[Address1];
  end
  assign dout0 = mem0[Address0];

  typedef struct {
    bit            done;
    bit            aerr;
    bit            en;
    bit            rw;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    bit            ld;
    logic [31:0]   rd;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
  int          done_cyc [2] = '{0, 0};
  int          busy_cnt [2] = '{0, 0};
  int          cyc = 0;
  int          req_cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          run = 1'b0;
  bit          clr_pend = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic exp_t blank();
    exp_t e;
    e.done = 1'b0; e.aerr = 1'b0; e.en = 1'b0; e.rw = 1'b0;
    e.addr = '0; e.din = '0; e.ld = 1'b0; e.rd = '0;
    return e;
  endfunction

  task automatic cmp(string nm, int k, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, k, cyc, act, want);
    end
  endtask

  task automatic push(int lat, exp_t e);
    if (lat == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic check(int k, bit h, exp_t e, logic busy, logic done, logic aerr, logic en,
                       logic rw, logic [AW-1:0] addr, logic [7:0] din, logic [31:0] rd);
    if (h && e.done && e.ld) exp_rd[k] = e.rd;
    if (done === 1'b1) done_cyc[k] = cyc;
    if (busy === 1'b1) busy_cnt[k]++;
    cmp("busy", k, 32'(busy), 32'(h));
    cmp("done", k, 32'(done), 32'(h && e.done));
    cmp("alignerr", k, 32'(aerr), 32'(h && e.aerr));
    cmp("enable", k, 32'(en), 32'(h && e.en));
    if (h && e.en) begin
      cmp("readwrite", k, 32'(rw), 32'(e.rw));
      cmp("address", k, 32'(addr), 32'(e.addr));
      if (e.rw) cmp("datain", k, 32'(din), 32'(e.din));
    end
    cmp("rdata", k, rd, exp_rd[k]);
  endtask

  // Per-cycle comparison of both DUTs against the scheduled expectations.
  always @(negedge Clk) begin
    exp_t e;
    bit   h;
    if (run) begin
      if (clr_pend) begin
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        clr_pend  = 1'b0;
      end
      h = (q0.size() > 0);
      e = h ? q0.pop_front() : blank();
      check(0, h, e, Busy0, Done0, AlignErr0, Enable0, ReadWrite0, Address0, DataIn0, RData0);
      h = (q1.size() > 0);
      e = h ? q1.pop_front() : blank();
      check(1, h, e, Busy1, Done1, AlignErr1, Enable1, ReadWrite1, Address1, DataIn1, RData1);
      if (Reset) clr_pend = 1'b1;
    end
  end

  // Issue one request (called one tick after a posedge with both DUTs idle) and
  // schedule the expected per-cycle behaviour from the transaction rules.
  // hold: extra edges Req stays high. abort_at: reset after this many XFER cycles.
  task automatic issue(bit wr, logic [1:0] size, bit sgn, logic [AW-1:0] addr,
                       logic [31:0] wdata, int hold, int abort_at);
    int            n;
    int            guard;
    bit            misal;
    logic [AW-1:0] base;
    logic [AW-1:0] a;
    logic [31:0]   val;
    exp_t          e;
    n     = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    misal = (32'(addr) % n) != 0;
    base  = misal ? (addr & ~AW'(n - 1)) : addr;
    Req = 1'b1; Wr = wr; Size = size; Signed = sgn; Addr = addr; WData = wdata;
    @(posedge Clk);
    #1;
    req_cyc = cyc;
    if (hold == 0) Req = 1'b0;
`ifdef RAM_SEQ_ALIGN_CHECK_EN
    if (misal) begin
      e = blank(); e.done = 1'b1; e.aerr = 1'b1;
      push(0, e); push(1, e);
    end else
`endif
    begin
      val = 32'h0;
      for (int j = 0; j < n; j++) begin
        a = base + AW'(j);
        e = blank(); e.en = 1'b1; e.rw = wr; e.addr = a;
        e.din = 8'(wdata >> (8 * (n - 1 - j)));
        if (abort_at == 0 || j < abort_at) begin
          push(0, e); push(1, e);
          if (wr) gold[a] = e.din;
        end
        if (!wr) val = (val << 8) | 32'(gold[a]);
      end
      if (abort_at == 0) begin
        if (!wr && n < 4 && sgn && val[8 * n - 1]) val = val | (32'hFFFF_FFFF << (8 * n));
        if (!wr) push(1, blank());
        e = blank(); e.done = 1'b1; e.ld = !wr; e.rd = val;
        push(0, e); push(1, e);
      end
    end
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(posedge Clk);
      #1 Reset = 1'b1;
      @(posedge Clk);
      #1 Reset = 1'b0;
    end
    if (hold > 0) begin
      repeat (hold) @(posedge Clk);
      #1 Req = 1'b0;
    end
    guard = 0;
    while ((q0.size() > 0 || q1.size() > 0) && guard < 30) begin
      @(posedge Clk);
      #1;
      guard++;
    end
    if (guard >= 30) begin
      bad++;
      $display("FAIL timeout waiting for Done got=busy want=idle");
      q0.delete();
      q1.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int nmem;
    for (int i = 0; i < MSZ; i++) gold[i] = 8'h0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    ram_clr = 1'b0;
    run = 1'b1;
    cmp("rst_rdata", 0, RData0, 32'h0);
    cmp("rst_busy", 0, 32'(Busy0), 32'h0);
    cmp("rst_enable", 1, 32'(Enable1), 32'h0);
    cmp("rst_address", 0, 32'(Address0), 32'h0);
    cmp("rst_datain", 1, 32'(DataIn1), 32'h0);
    cmp("rst_done", 1, 32'(Done1), 32'h0);

    issue(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEAD_BEEF, 0, 0);
    issue(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 0, 0);
    cmp("word_ld_val", 0, RData0, 32'hDEAD_BEEF);
    cmp("word_ld_val", 1, RData1, 32'hDEAD_BEEF);
    cmp("word_ld_lat", 0, done_cyc[0] - req_cyc + 1, 32'd5);
    cmp("word_ld_lat", 1, done_cyc[1] - req_cyc + 1, 32'd6);
    cmp("ram_010", 0, 32'(mem0[10'h010]), 32'hDE);
    cmp("ram_011", 0, 32'(mem0[10'h011]), 32'hAD);
    cmp("ram_012", 0, 32'(mem0[10'h012]), 32'hBE);
    cmp("ram_013", 0, 32'(mem0[10'h013]), 32'hEF);

    issue(1'b0, 2'b00, 1'b1, 10'h013, 32'h0, 0, 0);
    cmp("byte_ld_signed", 0, RData0, 32'hFFFF_FFEF);
    cmp("byte_ld_lat", 0, done_cyc[0] - req_cyc + 1, 32'd2);
    issue(1'b0, 2'b00, 1'b0, 10'h013, 32'h0, 0, 0);
    cmp("byte_ld_unsigned", 1, RData1, 32'h0000_00EF);

    issue(1'b1, 2'b01, 1'b0, 10'h3FE, 32'h0000_1234, 0, 0);
    issue(1'b0, 2'b01, 1'b0, 10'h3FE, 32'h0, 0, 0);
    cmp("half_ld_val", 1, RData1, 32'h0000_1234);
    cmp("half_ld_lat", 1, done_cyc[1] - req_cyc + 1, 32'd4);
    cmp("ram_3fe", 1, 32'(mem1[10'h3FE]), 32'h12);
    cmp("ram_3ff", 1, 32'(mem1[10'h3FF]), 32'h34);

    b0 = busy_cnt[0];
    issue(1'b1, 2'b10, 1'b0, 10'h040, 32'h0102_0304, 5, 0);
    cmp("held_req_busy_cycles", 0, busy_cnt[0] - b0, 32'd5);

    issue(1'b0, 2'b10, 1'b0, 10'h011, 32'h0, 0, 0);
`ifdef RAM_SEQ_ALIGN_CHECK_EN
    cmp("misalign_lat", 0, done_cyc[0] - req_cyc + 1, 32'd1);
    cmp("misalign_rdata", 0, RData0, 32'h0000_1234);
`else
    cmp("misalign_lat", 0, done_cyc[0] - req_cyc + 1, 32'd5);
    cmp("misalign_rdata", 0, RData0, 32'hDEAD_BEEF);
`endif

    issue(1'b1, 2'b10, 1'b0, 10'h020, 32'hAABB_CCDD, 0, 3);
    cmp("abort_busy", 0, 32'(Busy0), 32'h0);
    cmp("abort_ram_021", 0, 32'(mem0[10'h021]), 32'hBB);
    cmp("abort_ram_022", 0, 32'(mem0[10'h022]), 32'hCC);
    cmp("abort_ram_023", 1, 32'(mem1[10'h023]), 32'h00);

    for (int t = 0; t < 120; t++) begin
      int gap;
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            (t % 2 == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom), $urandom, 0, 0);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge Clk);
        #1;
      end
    end

    repeat (2) @(posedge Clk);
    #1;
    nmem = 0;
    for (int i = 0; i < MSZ; i++) begin
      if (mem0[i] !== gold[i] || mem1[i] !== gold[i]) nmem++;
    end
    cmp("ram_image_mismatches", 0, 32'(nmem), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_word_sequencer.md
Name: ram_word_sequencer

Overview:
- Sequences 8/16/32-bit MIPS load/store requests from the MEM stage onto the byte-wide 1024x8 data RAM.
- Issues one RAM byte access per cycle and assembles or splits data big-endian.
- Raises Busy while sequencing, then pulses Done with the assembled read data.
- Sits between the MEM stage and the data RAM instance; it is the RAM's only driver.

Parameters:
- ADDR_W, 10, RAM byte-address width; addresses wrap modulo 2^ADDR_W.
- RD_LATENCY, 0, RAM read latency in cycles: 0 = DataOut is valid in the same cycle as Address; 1 = DataOut is valid the following cycle.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Req  input  1  request strobe; sampled only in IDLE.
- Wr  input  1  1 = store, 0 = load.
- Size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- Signed  input  1  sign-extend byte/half loads.
- Addr  input  ADDR_W  byte address.
- WData  input  32  store data, right-justified.
- RData  output  32  load result; held until the next Done.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle completion pulse.
- AlignErr  output  1  pulses together with Done on a misaligned request (see Optional Feature).
- Enable  output  1  RAM enable.
- ReadWrite  output  1  RAM direction, 1 = write, 0 = read.
- Address  output  ADDR_W  RAM byte address.
- DataIn  output  8  byte to RAM.
- DataOut  input  8  byte from RAM.

Behaviour:
- Clock and reset: one clock, Clk; reset is synchronous and active-high on Reset.
- Reset values: state IDLE; Enable, ReadWrite, Address, DataIn, Busy, Done, AlignErr, RData all 0.
- Output timing: RAM-side outputs decode from registered state only; no combinational path from request inputs to RAM outputs.
- State IDLE:
  - On Req=1, latch Wr, Size, Signed, Addr, WData.
  - Set N = 1, 2 or 4 and idx = 0, then go to XFER.
  - Req=0: stay in IDLE.
- State XFER:
  - Drive Enable=1, ReadWrite=Wr, Address=base+idx.
  - Drive DataIn = byte idx of the N-byte store value, most-significant byte first. Word: WData[31:24] first. Half: WData[15:8] first. Byte: WData[7:0].
  - Reads with RD_LATENCY=0: capture DataOut into byte slot idx in this cycle.
  - Reads with RD_LATENCY=1: capture the byte for slot idx-1 when idx>0.
  - Increment idx each cycle. After idx=N-1, go to TAIL if (read and RD_LATENCY=1), otherwise go to DONE.
- State TAIL: Enable=0; capture the last byte; go to DONE.
- State DONE:
  - Enable=0; Done=1 for exactly this cycle.
  - For loads, RData updates at entry to DONE: word {b0,b1,b2,b3}; half {ext16,b0,b1}; byte {ext24,b0}.
  - ext = replicated MSB of b0 when Signed=1, zeros otherwise.
  - Stores leave RData unchanged.
  - Always go to IDLE next.
- Latency, counted from the Req-sampling edge: Done asserts N+1 cycles later, plus 1 for reads when RD_LATENCY=1. Word read at RD_LATENCY=0 gives Done in cycle 5.
- Req while Busy, including the DONE cycle, is ignored and not queued.
- Address arithmetic: base+idx wraps modulo 2^ADDR_W.
- Reset mid-operation: IDLE on the next edge with all outputs at reset values. Bytes already written stay written; the remaining bytes are not written.

Optional Feature:
- Macro: RAM_SEQ_ALIGN_CHECK_EN.
- Defined: a half request with Addr[0]=1, or a word request with Addr[1:0]!=0, goes from IDLE directly to DONE. Done=1 and AlignErr=1; Enable is never asserted; RData is unchanged.
- Undefined: AlignErr is tied to 0. Misaligned low address bits are forced to 0 (half base Addr&~1, word base Addr&~3) and the access proceeds normally.

Test Plan:
- Word store 0xDEADBEEF at 0x010, then word load at 0x010 (RD_LATENCY=0) -> RAM[0x10..0x13] = DE,AD,BE,EF; load Done exactly 5 cycles after Req; RData=0xDEADBEEF.
- Byte load at 0x013: Signed=1 -> RData=0xFFFFFFEF; Signed=0 -> RData=0x000000EF; Done 2 cycles after Req.
- Half store 0x1234 at 0x3FE, then half load (RD_LATENCY=1) -> RAM[1022]=0x12, RAM[1023]=0x34; RData=0x00001234; load Done 4 cycles after Req; Address never exceeds 1023.
- Req held high through a word store plus a second Req in the DONE cycle -> exactly one 4-byte transaction; Busy=1 for 5 cycles, then 0.
- Word load at 0x011 -> with macro: Done=AlignErr=1 one cycle after Req, Enable stays 0. Without macro: accesses 0x010-0x013, AlignErr=0.
- Reset asserted during the 3rd XFER cycle of a word store of 0xAABBCCDD at 0x020 over zeroed RAM -> next edge: Enable=0, Busy=0, Done=0; RAM[0x20..0x23] = AA,BB,CC,00.
